coords_frame_buffer: RTL and testbench
======================================

Name: coords_frame_buffer

Overview:
- Double-buffered (ping-pong) coordinate store between the video/pose pipeline (writer) and the Nios II coords RAM read port (reader).
- The CPU always reads a complete, frame-consistent set of coordinates; the pipeline writes the next frame into the back bank.
- Parametrised successor to the fixed 32-entry x 32-bit coordinate RAM path, adding frame publish/release handshake, frame sequencing and drop accounting.

Parameters:
- ADDR_W, 5, entry address width; each bank holds 2^ADDR_W entries.
- DATA_W, 32, coordinate word width.
- DROP_ON_BUSY, 1
  - 1: while a completed frame awaits CPU release, writer data is discarded.
  - 0: writer keeps overwriting the pending back bank (newest frame wins).

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe from pipeline
- wr_addr  in  ADDR_W  write entry index
- wr_data  in  DATA_W  write coordinate word
- wr_frame_end  in  1  single-cycle pulse: current back-bank frame complete
- rd_addr  in  ADDR_W  CPU read index
- rd_data  out  DATA_W  registered read data from front bank
- rd_release  in  1  single-cycle pulse: CPU finished with front bank
- frame_valid  out  1  front bank holds an unreleased published frame
- frame_seq  out  8  published-frame counter
- drop_count  out  8  dropped/overwritten-frame counter
- wr_bank  out  1  bank currently targeted by writes (debug)

Behaviour:
- Reset (sync, reset_reset=1 at a clk_clk edge):
  - front=0, state FREE, frame_valid=0, frame_seq=0, drop_count=0, rd_data=0, wr_bank=1.
  - RAM contents are not cleared.
  - Reset mid-frame abandons the partial frame; no drop is counted.
- Banks: back = ~front; wr_bank = back.
- Writes:
  - wr_en writes wr_data to back[wr_addr], except in PENDING with DROP_ON_BUSY=1, where writes are ignored.
  - A write in a swap cycle lands in the pre-swap back bank, i.e. the frame being published.
- Reads:
  - rd_data <= front[rd_addr] every cycle; latency 1.
  - The bank is selected by the pre-edge front value.
- States:
  - FREE: frame_valid=0.
  - HELD: frame_valid=1, CPU owns front.
  - PENDING: frame_valid=1 and back holds a complete frame awaiting release.
- A swap does all of the following in one edge: front toggles, frame_seq+1 (wraps at 255->0), frame_valid=1.
- Transitions from FREE:
  - wr_frame_end -> swap, go to HELD.
  - rd_release is ignored.
- Transitions from HELD:
  - rd_release only -> FREE, frame_valid=0.
  - wr_frame_end only -> PENDING.
  - Both in the same cycle -> swap, stay HELD.
- Transitions from PENDING:
  - rd_release only -> swap, go to HELD.
  - wr_frame_end only -> stay PENDING; drop_count+1.
    - DROP_ON_BUSY=1: the new frame is lost.
    - DROP_ON_BUSY=0: the older pending frame is overwritten.
  - Both in the same cycle:
    - DROP_ON_BUSY=0: swap, go to HELD, no drop.
    - DROP_ON_BUSY=1: swap, go to HELD, drop_count+1.
- drop_count saturates at 255.
- Pulses on wr_frame_end or rd_release longer than one cycle are treated as repeated events; the caller must pulse.

Decomposition:
- Package coords_fb_pkg holds:
  - state enum {FREE, HELD, PENDING};
  - SEQ_W=8 and CNT_W=8 constants;
  - saturating-increment function.
- One sub-module, coords_dp_ram:
  - simple dual-port RAM, depth 2^(ADDR_W+1), DATA_W wide;
  - one write port and one registered read port;
  - bank bit is the address MSB;
  - infers M10K.

Test Plan:
- Reset, then read addr 0..31 -> frame_valid=0, frame_seq=0, drop_count=0, rd_data=0 on the first cycle after reset.
- Write entries 0..31 = 0x100+i, pulse wr_frame_end -> next cycle frame_valid=1, frame_seq=1, wr_bank=0; rd_addr=5 gives rd_data=0x105 one cycle later.
- HELD, write a new frame (0x200+i), wr_frame_end -> PENDING; rd_addr=5 still 0x105. Pulse rd_release -> frame_seq=2; rd_addr=5 gives 0x205.
- PENDING, DROP_ON_BUSY=1: write 0x300+i, wr_frame_end -> drop_count=1. Release -> reads return 0x2xx, not 0x3xx. Repeat with DROP_ON_BUSY=0 -> reads return 0x3xx.
- HELD, rd_release and wr_frame_end in the same cycle, with wr_en to addr 31 in that cycle -> single swap, frame_valid stays 1, frame_seq+1, addr 31 readable in the new front.
- 300 forced drops -> drop_count holds 255. 256 publishes -> frame_seq wraps to 0. Reset asserted mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/coords_fb_pkg.sv
// Shared types and helpers for the ping-pong coordinate frame buffer.
package coords_fb_pkg;

    localparam int unsigned SEQ_W = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        HELD    = 2'd1,
        PENDING = 2'd2
    } fb_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/coords_frame_buffer_if.sv
// Pipeline write port, CPU read port and frame handshake of the coords frame buffer.
interface coords_frame_buffer_if
    import coords_fb_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) ();

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_frame_end;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_release;
    logic              frame_valid;
    logic [SEQ_W-1:0]  frame_seq;
    logic [CNT_W-1:0]  drop_count;
    logic              wr_bank;

    modport master (
        output wr_en, wr_addr, wr_data, wr_frame_end, rd_addr, rd_release,
        input  rd_data, frame_valid, frame_seq, drop_count, wr_bank
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_frame_end, rd_addr, rd_release,
        output rd_data, frame_valid, frame_seq, drop_count, wr_bank
    );

endinterface

// File: rtl/coords_dp_ram.sv
// Simple dual-port RAM, one write port and one registered read port (block-RAM friendly).
module coords_dp_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register clears on reset; array contents are left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/coords_frame_buffer.sv
// Ping-pong coordinate store: pipeline fills the back bank, CPU reads a published front bank.
module coords_frame_buffer
    import coords_fb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter bit          DROP_ON_BUSY = 1'b1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    coords_frame_buffer_if.slave   bus
);

    fb_state_e        state;
    logic             back;
    logic             frame_valid;
    logic [SEQ_W-1:0] frame_seq;
    logic [CNT_W-1:0] drop_count;
    logic             wr_accept;

    // Writes are parked while a finished frame waits, unless newest-frame-wins is selected.
    assign wr_accept = bus.wr_en && !reset_reset && !(DROP_ON_BUSY && (state == PENDING));

    coords_dp_ram #(
        .ADDR_W (ADDR_W + 1),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .we    (wr_accept),
        .waddr ({back, bus.wr_addr}),
        .wdata (bus.wr_data),
        .raddr ({~back, bus.rd_addr}),
        .rdata (bus.rd_data)
    );

    assign bus.frame_valid = frame_valid;
    assign bus.frame_seq   = frame_seq;
    assign bus.drop_count  = drop_count;
    assign bus.wr_bank     = back;

    // Publish/release FSM; a swap toggles banks, bumps the sequence and marks the front valid.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= FREE;
            back        <= 1'b1;
            frame_valid <= 1'b0;
            frame_seq   <= '0;
            drop_count  <= '0;
        end else begin
            case (state)
                FREE: begin
                    if (bus.wr_frame_end) begin
                        back        <= ~back;
                        frame_seq   <= frame_seq + SEQ_W'(1);
                        frame_valid <= 1'b1;
                        state       <= HELD;
                    end
                end
                HELD: begin
                    if (bus.wr_frame_end && bus.rd_release) begin
                        back        <= ~back;
                        frame_seq   <= frame_seq + SEQ_W'(1);
                        frame_valid <= 1'b1;
                    end else if (bus.rd_release) begin
                        frame_valid <= 1'b0;
                        state       <= FREE;
                    end else if (bus.wr_frame_end) begin
                        state       <= PENDING;
                    end
                end
                PENDING: begin
                    if (bus.rd_release) begin
                        back        <= ~back;
                        frame_seq   <= frame_seq + SEQ_W'(1);
                        frame_valid <= 1'b1;
                        state       <= HELD;
                        if (bus.wr_frame_end && DROP_ON_BUSY) begin
                            drop_count <= sat_inc(drop_count);
                        end
                    end else if (bus.wr_frame_end) begin
                        drop_count <= sat_inc(drop_count);
                    end
                end
                default: begin
                    state <= FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coords_frame_buffer.sv
// Directed bench driving a drop-on-busy and a newest-wins instance with identical stimulus.
module tb_coords_frame_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_frame_end;
    logic [4:0]  rd_addr;
    logic        rd_release;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    coords_frame_buffer_if #(.ADDR_W(5), .DATA_W(32)) bus1 ();
    coords_frame_buffer_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();

    assign bus1.wr_en = wr_en;               assign bus0.wr_en = wr_en;
    assign bus1.wr_addr = wr_addr;           assign bus0.wr_addr = wr_addr;
    assign bus1.wr_data = wr_data;           assign bus0.wr_data = wr_data;
    assign bus1.wr_frame_end = wr_frame_end; assign bus0.wr_frame_end = wr_frame_end;
    assign bus1.rd_addr = rd_addr;           assign bus0.rd_addr = rd_addr;
    assign bus1.rd_release = rd_release;     assign bus0.rd_release = rd_release;

    coords_frame_buffer #(.ADDR_W(5), .DATA_W(32), .DROP_ON_BUSY(1'b1)) dut1 (
        .clk_clk(clk), .reset_reset(rst), .bus(bus1));
    coords_frame_buffer #(.ADDR_W(5), .DATA_W(32), .DROP_ON_BUSY(1'b0)) dut0 (
        .clk_clk(clk), .reset_reset(rst), .bus(bus0));

    // Status vector: {frame_valid, frame_seq, drop_count, wr_bank}
    function automatic logic [17:0] st1();
        return {bus1.frame_valid, bus1.frame_seq, bus1.drop_count, bus1.wr_bank};
    endfunction
    function automatic logic [17:0] st0();
        return {bus0.frame_valid, bus0.frame_seq, bus0.drop_count, bus0.wr_bank};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_frame(input logic [31:0] base);
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = base + 32'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_fe();
        wr_frame_end = 1'b1; tick(); wr_frame_end = 1'b0;
    endtask

    task automatic pulse_rel();
        rd_release = 1'b1; tick(); rd_release = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d1, output logic [31:0] d0);
        rd_addr = a; tick(); d1 = bus1.rd_data; d0 = bus0.rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_frame_end = 1'b0; rd_addr = '0; rd_release = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (st1() !== {1'b0, 8'd0, 8'd0, 1'b1}) $display("FAIL reset_status d1 got %h exp %h", st1(), {1'b0, 8'd0, 8'd0, 1'b1}); else passes++;
        checks++; if (st0() !== {1'b0, 8'd0, 8'd0, 1'b1}) $display("FAIL reset_status d0 got %h exp %h", st0(), {1'b0, 8'd0, 8'd0, 1'b1}); else passes++;
        checks++; if (bus1.rd_data !== 32'd0) $display("FAIL reset_rd_data d1 got %h exp 0", bus1.rd_data); else passes++;
        checks++; if (bus0.rd_data !== 32'd0) $display("FAIL reset_rd_data d0 got %h exp 0", bus0.rd_data); else passes++;
    endtask

    task automatic test_first_frame();
        logic [31:0] d1, d0;
        write_frame(32'h100);
        pulse_fe();
        checks++; if (st1() !== {1'b1, 8'd1, 8'd0, 1'b0}) $display("FAIL first_status d1 got %h exp %h", st1(), {1'b1, 8'd1, 8'd0, 1'b0}); else passes++;
        checks++; if (st0() !== {1'b1, 8'd1, 8'd0, 1'b0}) $display("FAIL first_status d0 got %h exp %h", st0(), {1'b1, 8'd1, 8'd0, 1'b0}); else passes++;
        do_read(5'd5, d1, d0);
        checks++; if (d1 !== 32'h105) $display("FAIL first_read5 d1 got %h exp 105", d1); else passes++;
        checks++; if (d0 !== 32'h105) $display("FAIL first_read5 d0 got %h exp 105", d0); else passes++;
    endtask

    task automatic test_pending();
        logic [31:0] d1, d0;
        write_frame(32'h200);
        pulse_fe();
        checks++; if (st1() !== {1'b1, 8'd1, 8'd0, 1'b0}) $display("FAIL pending_status d1 got %h exp %h", st1(), {1'b1, 8'd1, 8'd0, 1'b0}); else passes++;
        do_read(5'd5, d1, d0);
        checks++; if (d1 !== 32'h105 || d0 !== 32'h105) $display("FAIL pending_front_kept got %h/%h exp 105/105", d1, d0); else passes++;
        pulse_rel();
        checks++; if (st1() !== {1'b1, 8'd2, 8'd0, 1'b1}) $display("FAIL release_swap d1 got %h exp %h", st1(), {1'b1, 8'd2, 8'd0, 1'b1}); else passes++;
        checks++; if (st0() !== {1'b1, 8'd2, 8'd0, 1'b1}) $display("FAIL release_swap d0 got %h exp %h", st0(), {1'b1, 8'd2, 8'd0, 1'b1}); else passes++;
        do_read(5'd5, d1, d0);
        checks++; if (d1 !== 32'h205 || d0 !== 32'h205) $display("FAIL release_read5 got %h/%h exp 205/205", d1, d0); else passes++;
    endtask

    task automatic test_drop();
        logic [31:0] d1, d0;
        write_frame(32'h250);
        pulse_fe();
        write_frame(32'h300);
        pulse_fe();
        checks++; if (st1() !== {1'b1, 8'd2, 8'd1, 1'b1}) $display("FAIL drop_count d1 got %h exp %h", st1(), {1'b1, 8'd2, 8'd1, 1'b1}); else passes++;
        checks++; if (st0() !== {1'b1, 8'd2, 8'd1, 1'b1}) $display("FAIL drop_count d0 got %h exp %h", st0(), {1'b1, 8'd2, 8'd1, 1'b1}); else passes++;
        pulse_rel();
        checks++; if (st1() !== {1'b1, 8'd3, 8'd1, 1'b0}) $display("FAIL drop_release d1 got %h exp %h", st1(), {1'b1, 8'd3, 8'd1, 1'b0}); else passes++;
        do_read(5'd5, d1, d0);
        checks++; if (d1 !== 32'h255) $display("FAIL drop_kept_old d1 got %h exp 255", d1); else passes++;
        checks++; if (d0 !== 32'h305) $display("FAIL newest_wins d0 got %h exp 305", d0); else passes++;
        do_read(5'd31, d1, d0);
        checks++; if (d1 !== 32'h26f || d0 !== 32'h31f) $display("FAIL drop_read31 got %h/%h exp 26f/31f", d1, d0); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d0;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'habc;
        wr_frame_end = 1'b1; rd_release = 1'b1;
        tick();
        wr_en = 1'b0; wr_frame_end = 1'b0; rd_release = 1'b0;
        checks++; if (st1() !== {1'b1, 8'd4, 8'd1, 1'b1}) $display("FAIL b2b_status d1 got %h exp %h", st1(), {1'b1, 8'd4, 8'd1, 1'b1}); else passes++;
        checks++; if (st0() !== {1'b1, 8'd4, 8'd1, 1'b1}) $display("FAIL b2b_status d0 got %h exp %h", st0(), {1'b1, 8'd4, 8'd1, 1'b1}); else passes++;
        do_read(5'd31, d1, d0);
        checks++; if (d1 !== 32'habc || d0 !== 32'habc) $display("FAIL b2b_read31 got %h/%h exp abc/abc", d1, d0); else passes++;
        do_read(5'd5, d1, d0);
        checks++; if (d1 !== 32'h205 || d0 !== 32'h205) $display("FAIL b2b_read5 got %h/%h exp 205/205", d1, d0); else passes++;
    endtask

    task automatic test_pending_both();
        logic [31:0] d1, d0;
        pulse_fe();
        wr_frame_end = 1'b1; rd_release = 1'b1;
        tick();
        wr_frame_end = 1'b0; rd_release = 1'b0;
        checks++; if (st1() !== {1'b1, 8'd5, 8'd2, 1'b0}) $display("FAIL pend_both d1 got %h exp %h", st1(), {1'b1, 8'd5, 8'd2, 1'b0}); else passes++;
        checks++; if (st0() !== {1'b1, 8'd5, 8'd1, 1'b0}) $display("FAIL pend_both d0 got %h exp %h", st0(), {1'b1, 8'd5, 8'd1, 1'b0}); else passes++;
        do_read(5'd5, d1, d0);
        checks++; if (d1 !== 32'h255 || d0 !== 32'h305) $display("FAIL pend_both_read5 got %h/%h exp 255/305", d1, d0); else passes++;
    endtask

    task automatic test_drop_saturate();
        pulse_fe();
        wr_frame_end = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        wr_frame_end = 1'b0;
        checks++; if (st1() !== {1'b1, 8'd5, 8'd255, 1'b0}) $display("FAIL drop_sat d1 got %h exp %h", st1(), {1'b1, 8'd5, 8'd255, 1'b0}); else passes++;
        checks++; if (st0() !== {1'b1, 8'd5, 8'd255, 1'b0}) $display("FAIL drop_sat d0 got %h exp %h", st0(), {1'b1, 8'd5, 8'd255, 1'b0}); else passes++;
        pulse_rel();
        checks++; if (st1() !== {1'b1, 8'd6, 8'd255, 1'b1}) $display("FAIL drop_sat_release d1 got %h exp %h", st1(), {1'b1, 8'd6, 8'd255, 1'b1}); else passes++;
    endtask

    task automatic test_seq_wrap();
        wr_frame_end = 1'b1; rd_release = 1'b1;
        for (int i = 0; i < 249; i++) tick();
        checks++; if (st1() !== {1'b1, 8'd255, 8'd255, 1'b0}) $display("FAIL seq_255 d1 got %h exp %h", st1(), {1'b1, 8'd255, 8'd255, 1'b0}); else passes++;
        tick();
        wr_frame_end = 1'b0; rd_release = 1'b0;
        checks++; if (st1() !== {1'b1, 8'd0, 8'd255, 1'b1}) $display("FAIL seq_wrap d1 got %h exp %h", st1(), {1'b1, 8'd0, 8'd255, 1'b1}); else passes++;
        checks++; if (st0() !== {1'b1, 8'd0, 8'd255, 1'b1}) $display("FAIL seq_wrap d0 got %h exp %h", st0(), {1'b1, 8'd0, 8'd255, 1'b1}); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h400 + 32'(i);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        checks++; if (st1() !== {1'b0, 8'd0, 8'd0, 1'b1}) $display("FAIL midreset_status d1 got %h exp %h", st1(), {1'b0, 8'd0, 8'd0, 1'b1}); else passes++;
        checks++; if (st0() !== {1'b0, 8'd0, 8'd0, 1'b1}) $display("FAIL midreset_status d0 got %h exp %h", st0(), {1'b0, 8'd0, 8'd0, 1'b1}); else passes++;
        checks++; if (bus1.rd_data !== 32'd0 || bus0.rd_data !== 32'd0) $display("FAIL midreset_rd_data got %h/%h exp 0/0", bus1.rd_data, bus0.rd_data); else passes++;
        pulse_fe();
        checks++; if (st1() !== {1'b1, 8'd1, 8'd0, 1'b0}) $display("FAIL post_reset_publish d1 got %h exp %h", st1(), {1'b1, 8'd1, 8'd0, 1'b0}); else passes++;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_pending();
        test_drop();
        test_back_to_back();
        test_pending_both();
        test_drop_saturate();
        test_seq_wrap();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
